// File: rtl/axi_master_arbiter_if.sv
// rtl/axi_master_arbiter_if.sv - AXI master channel bundle (AR/R/AW/W/B) for the two-client arbiter
interface axi_master_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int ID_W   = 4
);
  logic              ARVALID;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [ID_W-1:0]   ARID;
  logic              ARREADY;

  logic              RVALID;
  logic [DATA_W-1:0] RDATA;
  logic              RLAST;
  logic [1:0]        RRESP;
  logic              RREADY;

  logic              AWVALID;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [ID_W-1:0]   AWID;
  logic              AWREADY;

  logic              WVALID;
  logic [DATA_W-1:0] WDATA;
  logic              WLAST;
  logic              WREADY;

  logic              BVALID;
  logic [1:0]        BRESP;
  logic              BREADY;

  modport master (
    output ARVALID, ARADDR, ARLEN, ARID, input ARREADY,
    input  RVALID, RDATA, RLAST, RRESP, output RREADY,
    output AWVALID, AWADDR, AWLEN, AWID, input AWREADY,
    output WVALID, WDATA, WLAST, input WREADY,
    input  BVALID, BRESP, output BREADY
  );

  modport slave (
    input  ARVALID, ARADDR, ARLEN, ARID, output ARREADY,
    output RVALID, RDATA, RLAST, RRESP, input RREADY,
    input  AWVALID, AWADDR, AWLEN, AWID, output AWREADY,
    input  WVALID, WDATA, WLAST, output WREADY,
    output BVALID, BRESP, input BREADY
  );
endinterface

// File: rtl/axi_master_arbiter.sv
// rtl/axi_master_arbiter.sv - round-robin two-client burst sequencer driving one AXI master port
module axi_master_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*LEN_W-1:0]  len,
  input  logic [2*ID_W-1:0]   id,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          wnext,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          done,
  output logic [1:0]          resp,
  axi_master_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;

  state_t            state, state_n;
  logic              cur, last_gnt, win;
  logic [ADDR_W-1:0] cap_addr;
  logic [LEN_W-1:0]  cap_len;
  logic [ID_W-1:0]   cap_id;
  logic [LEN_W:0]    beat, beat_inc;
  logic [1:0]        resp_acc, resp_q, resp_max;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rvalid_q;
  logic              wlast;

  // Tie-break favours the client that did not win last time
  assign win      = (req == 2'b11) ? ~last_gnt : req[1];
  assign beat_inc = beat + 1'b1;
  assign wlast    = (beat == {1'b0, cap_len});
  assign resp_max = (bus.RRESP > resp_acc) ? bus.RRESP : resp_acc;

  assign bus.ARADDR = cap_addr;
  assign bus.ARLEN  = cap_len;
  assign bus.ARID   = cap_id;
  assign bus.AWADDR = cap_addr;
  assign bus.AWLEN  = cap_len;
  assign bus.AWID   = cap_id;

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    gnt         = '0;
    wnext       = '0;
    done        = '0;
    resp        = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    bus.WDATA   = '0;
    bus.WLAST   = 1'b0;
    bus.BREADY  = 1'b0;
    case (state)
      IDLE: if (!rst && (|req)) begin
        gnt[win] = 1'b1;
        state_n  = we[win] ? AW : AR;
      end
      AR: begin
        bus.ARVALID = 1'b1;
        if (bus.ARREADY) state_n = R;
      end
      R: begin
        bus.RREADY = 1'b1;
        if (bus.RVALID && bus.RLAST) state_n = DONE;
      end
      AW: begin
        bus.AWVALID = 1'b1;
        if (bus.AWREADY) state_n = W;
      end
      W: begin
        bus.WVALID = 1'b1;
        bus.WDATA  = cur ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        bus.WLAST  = wlast;
        if (bus.WREADY) begin
          wnext[cur] = 1'b1;
          if (wlast) state_n = B;
        end
      end
      B: begin
        bus.BREADY = 1'b1;
        if (bus.BVALID) state_n = DONE;
      end
      DONE: begin
        done[cur] = 1'b1;
        resp      = resp_q;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= 1'b0;
      last_gnt <= 1'b1;
      cap_addr <= '0;
      cap_len  <= '0;
      cap_id   <= '0;
      beat     <= '0;
      resp_acc <= '0;
      resp_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= '0;
      case (state)
        IDLE: if (|req) begin
          cur      <= win;
          cap_addr <= win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
          cap_len  <= win ? len[2*LEN_W-1:LEN_W]    : len[LEN_W-1:0];
          cap_id   <= win ? id[2*ID_W-1:ID_W]       : id[ID_W-1:0];
        end
        R: if (bus.RVALID) begin
          rdata_q       <= bus.RDATA;
          rvalid_q[cur] <= 1'b1;
          beat          <= beat_inc;
          resp_acc      <= resp_max;
          // A short or long burst overrides whatever the slave reported
          if (bus.RLAST)
            resp_q <= (beat_inc != ({1'b0, cap_len} + 1'b1)) ? 2'b10 : resp_max;
        end
        W: if (bus.WREADY) beat <= beat_inc;
        B: if (bus.BVALID) resp_q <= bus.BRESP;
        DONE: begin
          last_gnt <= cur;
          beat     <= '0;
          resp_acc <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb/tb_axi_master_arbiter.sv - scoreboard bench for axi_master_arbiter
module tb_axi_master_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [15:0] addr;
  logic [7:0]  len, id;
  logic [15:0] wdata;
  logic [1:0]  gnt, wnext, rvalid, done, resp;
  logic [7:0]  rdata;

  axi_master_arbiter_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .ID_W(4)) bus();

  axi_master_arbiter #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .ID_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .len(len), .id(id),
    .wdata(wdata), .gnt(gnt), .wnext(wnext), .rvalid(rvalid), .rdata(rdata),
    .done(done), .resp(resp), .bus(bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic        q_gnt[$];
  logic [15:0] q_ar[$], q_aw[$];
  logic [8:0]  q_rd[$];
  logic [9:0]  q_w[$];
  logic [2:0]  q_done[$];
  logic [7:0]  wq0[$], wq1[$];
  logic [7:0]  rbeats[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

  // Scoreboard monitor: samples on the falling edge, pops one expectation per observed event
  initial begin : monitor
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rst, c, l;
    logic [15:0] p_ar, p_aw, ea;
    logic [7:0]  p_wd, d;
    logic        p_wl;
    logic [8:0]  er;
    logic [9:0]  ew;
    logic [2:0]  ed;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_rst = 1;
    p_ar = 0; p_aw = 0; p_wd = 0; p_wl = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (gnt != 2'b00) begin
          check("gnt_onehot", $countones(gnt), 1);
          if (q_gnt.size() == 0) check("gnt_unexpected", gnt, 0);
          else begin c = q_gnt.pop_front(); check("gnt_client", gnt, oh(c)); end
        end
        if (rvalid != 2'b00) begin
          if (q_rd.size() == 0) check("rvalid_unexpected", rvalid, 0);
          else begin er = q_rd.pop_front(); check("rdata", {rvalid, rdata}, {oh(er[8]), er[7:0]}); end
        end
        if (done != 2'b00) begin
          if (q_done.size() == 0) check("done_unexpected", done, 0);
          else begin ed = q_done.pop_front(); check("done_resp", {done, resp}, {oh(ed[2]), ed[1:0]}); end
        end
        if (bus.ARVALID && bus.ARREADY) begin
          if (q_ar.size() == 0) check("ar_unexpected", bus.ARVALID, 0);
          else begin ea = q_ar.pop_front(); check("ar_fields", {bus.ARADDR, bus.ARLEN, bus.ARID}, ea); end
        end
        if (bus.AWVALID && bus.AWREADY) begin
          if (q_aw.size() == 0) check("aw_unexpected", bus.AWVALID, 0);
          else begin ea = q_aw.pop_front(); check("aw_fields", {bus.AWADDR, bus.AWLEN, bus.AWID}, ea); end
        end
        if (bus.WVALID && bus.WREADY) begin
          if (q_w.size() == 0) check("w_unexpected", bus.WVALID, 0);
          else begin
            ew = q_w.pop_front(); c = ew[9]; l = ew[8]; d = ew[7:0];
            check("w_beat", {wnext, bus.WLAST, bus.WDATA}, {oh(c), l, d});
          end
        end else if (wnext != 2'b00) check("wnext_unexpected", wnext, 0);
        if (!p_rst) begin
          if (p_arv && !p_arr) check("ar_hold", {bus.ARVALID, bus.ARADDR, bus.ARLEN, bus.ARID}, {1'b1, p_ar});
          if (p_awv && !p_awr) check("aw_hold", {bus.AWVALID, bus.AWADDR, bus.AWLEN, bus.AWID}, {1'b1, p_aw});
          if (p_wv && !p_wr) check("w_hold", {bus.WVALID, bus.WLAST, bus.WDATA}, {1'b1, p_wl, p_wd});
        end
      end
      p_rst = rst;
      p_arv = bus.ARVALID; p_arr = bus.ARREADY; p_ar = {bus.ARADDR, bus.ARLEN, bus.ARID};
      p_awv = bus.AWVALID; p_awr = bus.AWREADY; p_aw = {bus.AWADDR, bus.AWLEN, bus.AWID};
      p_wv = bus.WVALID; p_wr = bus.WREADY; p_wd = bus.WDATA; p_wl = bus.WLAST;
    end
  end

  task automatic set_wdata();
    wdata[7:0]  = (wq0.size() > 0) ? wq0[0] : 8'h00;
    wdata[15:8] = (wq1.size() > 0) ? wq1[0] : 8'h00;
  endtask

  // One clock: clients drop req on gnt and advance wdata on wnext
  task automatic cycle();
    logic [1:0] g, wn;
    #1;
    g = gnt; wn = wnext;
    @(posedge clk); #1;
    req = req & ~g;
    if (wn[0] && wq0.size() > 0) wq0.delete(0);
    if (wn[1] && wq1.size() > 0) wq1.delete(0);
    set_wdata();
  endtask

  task automatic post(input int c, input logic w, input logic [7:0] a, input logic [3:0] l, input logic [3:0] i);
    we[c] = w; addr[c*8 +: 8] = a; len[c*4 +: 4] = l; id[c*4 +: 4] = i; req[c] = 1'b1;
    if (w) q_aw.push_back({a, l, i});
    else   q_ar.push_back({a, l, i});
  endtask

  task automatic push_reads(input logic c);
    foreach (rbeats[k]) q_rd.push_back({c, rbeats[k]});
  endtask

  task automatic serve_read(input int ar_wait, input logic [1:0] rr);
    int t;
    t = 0; #1;
    while (!bus.ARVALID) begin
      if (++t > 40) begin check("arvalid_timeout", bus.ARVALID, 1); return; end
      cycle(); #1;
    end
    repeat (ar_wait) cycle();
    bus.ARREADY = 1'b1; cycle(); bus.ARREADY = 1'b0;
    foreach (rbeats[k]) begin
      bus.RVALID = 1'b1; bus.RDATA = rbeats[k]; bus.RLAST = (k == rbeats.size() - 1); bus.RRESP = rr;
      #1;
      if (!bus.RREADY) begin check("rready", bus.RREADY, 1); break; end
      cycle();
    end
    bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RDATA = 8'h00; bus.RRESP = 2'b00;
    rbeats.delete();
  endtask

  task automatic serve_write(input int gap, input logic [1:0] br);
    int t;
    logic last;
    t = 0; #1;
    while (!bus.AWVALID) begin
      if (++t > 40) begin check("awvalid_timeout", bus.AWVALID, 1); return; end
      cycle(); #1;
    end
    bus.AWREADY = 1'b1; cycle(); bus.AWREADY = 1'b0;
    last = 1'b0; t = 0;
    while (!last) begin
      repeat (gap) cycle();
      bus.WREADY = 1'b1; #1;
      if (!bus.WVALID || ++t > 17) begin check("wvalid_wlast", bus.WVALID & bus.WLAST, 1); bus.WREADY = 1'b0; return; end
      last = bus.WLAST;
      cycle();
      bus.WREADY = 1'b0;
    end
    bus.BVALID = 1'b1; bus.BRESP = br; #1;
    if (!bus.BREADY) check("bready", bus.BREADY, 1);
    cycle();
    bus.BVALID = 1'b0; bus.BRESP = 2'b00;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int t;
    rst = 1'b1; req = 0; we = 0; addr = 0; len = 0; id = 0; wdata = 0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RLAST = 0; bus.RRESP = 0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_client_outs", {gnt, wnext, rvalid, done, resp, rdata}, 0);
    check("reset_bus_outs", {bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY,
                             bus.ARADDR, bus.AWADDR}, 0);
    rst = 1'b0;

    // single read, ARREADY delayed two cycles
    q_gnt.push_back(1'b0);
    post(0, 1'b0, 8'h40, 4'd3, 4'd5);
    rbeats = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_reads(1'b0);
    q_done.push_back({1'b0, 2'b00});
    serve_read(2, 2'b00);
    repeat (2) cycle();

    // single write, WREADY low one cycle per beat
    wq1 = {8'h5A, 8'hA5}; set_wdata();
    q_gnt.push_back(1'b1);
    post(1, 1'b1, 8'h10, 4'd1, 4'd3);
    q_w.push_back({1'b1, 1'b0, 8'h5A});
    q_w.push_back({1'b1, 1'b1, 8'hA5});
    q_done.push_back({1'b1, 2'b01});
    serve_write(1, 2'b01);
    repeat (2) cycle();

    // contention from reset: expected grant order 0,1,0,1
    rst = 1'b1; cycle(); rst = 1'b0;
    q_gnt.push_back(1'b0); q_gnt.push_back(1'b1); q_gnt.push_back(1'b0); q_gnt.push_back(1'b1);
    post(0, 1'b0, 8'h20, 4'd0, 4'd1);
    rbeats = {8'h31}; push_reads(1'b0);
    q_done.push_back({1'b0, 2'b00});
    wq1 = {8'h11}; set_wdata();
    post(1, 1'b1, 8'h30, 4'd0, 4'd2);
    q_w.push_back({1'b1, 1'b1, 8'h11});
    q_done.push_back({1'b1, 2'b00});
    serve_read(0, 2'b00);
    post(0, 1'b0, 8'h21, 4'd0, 4'd1);
    rbeats = {8'h32}; push_reads(1'b0);
    q_done.push_back({1'b0, 2'b00});
    serve_write(0, 2'b00);
    wq1 = {8'h22}; set_wdata();
    post(1, 1'b1, 8'h31, 4'd0, 4'd2);
    q_w.push_back({1'b1, 1'b1, 8'h22});
    q_done.push_back({1'b1, 2'b00});
    serve_read(0, 2'b00);
    serve_write(0, 2'b00);
    repeat (2) cycle();

    // RLAST one beat early: len=2 but only two beats
    q_gnt.push_back(1'b0);
    post(0, 1'b0, 8'h55, 4'd2, 4'd7);
    rbeats = {8'h01, 8'h02}; push_reads(1'b0);
    q_done.push_back({1'b0, 2'b10});
    serve_read(1, 2'b00);
    cycle(); #1;
    check("idle_after_mismatch", {bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY}, 0);

    // reset after the first of four write beats
    wq1 = {8'h41, 8'h42, 8'h43, 8'h44}; set_wdata();
    q_gnt.push_back(1'b1);
    post(1, 1'b1, 8'h60, 4'd3, 4'd9);
    q_w.push_back({1'b1, 1'b0, 8'h41});
    t = 0; #1;
    while (!bus.AWVALID && t < 40) begin t++; cycle(); #1; end
    check("aw_before_reset", bus.AWVALID, 1);
    bus.AWREADY = 1'b1; cycle(); bus.AWREADY = 1'b0;
    bus.WREADY = 1'b1; cycle(); bus.WREADY = 1'b0;
    cycle();
    rst = 1'b1; cycle(); #1;
    check("wvalid_after_rst", bus.WVALID, 0);
    check("outs_after_rst", {gnt, wnext, rvalid, done, resp, bus.ARVALID, bus.RREADY, bus.AWVALID, bus.BREADY}, 0);
    rst = 1'b0; wq1.delete(); set_wdata();
    q_gnt.push_back(1'b0);
    post(0, 1'b0, 8'h70, 4'd0, 4'd2);
    rbeats = {8'hEE}; push_reads(1'b0);
    q_done.push_back({1'b0, 2'b00});
    serve_read(1, 2'b00);
    repeat (3) cycle();

    check("left_gnt", q_gnt.size(), 0);
    check("left_ar", q_ar.size(), 0);
    check("left_aw", q_aw.size(), 0);
    check("left_rd", q_rd.size(), 0);
    check("left_w", q_w.size(), 0);
    check("left_done", q_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axi_master_arbiter.md
Name: axi_master_arbiter

Overview:
- Two-requester arbiter and transaction sequencer in front of the single AXI master port (AR/R/AW/W/B channels, 8-bit address/data, 4-bit LEN/ID).
- Each client posts one burst descriptor (read or write). The block grants clients round-robin, drives the full channel handshake sequence for the winning burst, and returns read data and a completion response to that client.
- It sits between the client logic and the AXI protocol block, and is the only driver of the master channel signals.

Parameters:
ADDR_W, 8, address width per descriptor
DATA_W, 8, data beat width
LEN_W, 4, burst length field (beats = LEN+1)
ID_W, 4, transaction ID width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  2  per-client request, held until gnt
we  in  2  per-client 1=write, 0=read
addr  in  2*ADDR_W  per-client start address, client i at [i*ADDR_W +: ADDR_W]
len  in  2*LEN_W  per-client burst length field
id  in  2*ID_W  per-client ID
wdata  in  2*DATA_W  per-client write data, current beat
gnt  out  2  one-cycle pulse: descriptor captured
wnext  out  2  one-cycle pulse: current wdata beat consumed
rvalid  out  2  one-cycle pulse: rdata valid for that client
rdata  out  DATA_W  registered read beat
done  out  2  one-cycle pulse: burst complete
resp  out  2  completion response, valid while done is high
ARVALID/ARADDR/ARLEN/ARID  out  1/8/4/4  read address channel
ARREADY  in  1
RVALID/RDATA/RLAST/RRESP  in  1/8/1/2  read data channel
RREADY  out  1
AWVALID/AWADDR/AWLEN/AWID  out  1/8/4/4  write address channel
AWREADY  in  1
WVALID/WDATA/WLAST  out  1/8/1  write data channel
WREADY  in  1
BVALID/BRESP  in  1/2  write response channel
BREADY  out  1

Behaviour:
- Reset: FSM=IDLE; all outputs 0; beat counter, error flags and captured descriptor cleared; last-grant pointer=1, so client 0 wins first.
- FSM states: IDLE, AR, R, AW, W, B, DONE. Exactly one burst is in flight at any time.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise pick the winner. A single requester wins outright. If both request, the client not equal to the last-grant pointer wins.
  - Capture we/addr/len/id of the winner and pulse gnt[w] in the same cycle.
  - Next state is AW if we=1, else AR.
- AR: ARVALID=1 with the captured fields held stable. Leave on the cycle ARVALID&&ARREADY (go to R); ARVALID is low the next cycle.
- R:
  - RREADY=1.
  - Each RVALID&&RREADY: rdata<=RDATA, rvalid[w]<=1 on the next cycle, beat++, resp_acc<=max(resp_acc,RRESP).
  - On a beat with RLAST: go to DONE. If beat count != LEN+1, resp is forced to 2'b10.
  - Beats beyond LEN+1 without RLAST are still forwarded; the mismatch error is flagged at RLAST.
- AW: AWVALID=1 until AWREADY is sampled, then go to W.
- W:
  - WVALID=1; WDATA=wdata of the winner (combinational mux); WLAST=1 when beat==LEN.
  - On WVALID&&WREADY: wnext[w]=1 in the same cycle, beat++.
  - The beat with WLAST goes to B.
- B: BREADY=1. On BVALID, capture BRESP into resp and go to B→DONE.
- DONE:
  - done[w]=1 and resp valid for one cycle.
  - Last-grant pointer<=w; beat/resp_acc cleared; go to IDLE.
  - The minimum gap between bursts is IDLE+DONE: 2 cycles with no channel activity.
- Request handling:
  - A req deasserted before gnt is dropped silently.
  - A req held during another client's burst is serviced next.
  - Descriptor inputs are ignored after gnt.
- Reset mid-burst: the next edge returns to IDLE with all VALID/READY low. No done pulse; the in-flight burst is abandoned.
- A VALID asserted by the block stays asserted until its handshake; it is never withdrawn except by rst.
- Beat counter is LEN_W+1 bits wide, so it cannot wrap on LEN=15 plus one overrun beat.

Test Plan:
- Single read: client0 read, addr=8'h40, len=3, id=5; ARREADY after 2 cycles; 4 RDATA beats AA,BB,CC,DD with RLAST on the 4th -> ARADDR=40/ARLEN=3/ARID=5 held stable; rvalid[0] pulses 4× with rdata AA..DD; done[0]=1 with resp=00.
- Single write: client1 write, addr=8'h10, len=1; WREADY low 1 cycle per beat -> WVALID held high; wnext[1] fires twice; WLAST only on the 2nd beat; BRESP=01 -> done[1] with resp=01.
- Contention: both clients req in the same cycle from reset, each re-requesting after done -> grant order 0,1,0,1; gnt never goes to both clients.
- RLAST mismatch: read len=2, RLAST on the 2nd beat -> done with resp=10; FSM back in IDLE.
- Reset mid-W: rst asserted after 1 of 4 beats -> WVALID=0 the next cycle; no done; a following read from client0 completes normally.
